// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_pkg                                                      |
// | Description : Shared SPI definitions: state encodings, mode-0 idle levels  |
// |               and the bit-counter width helper.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package spi_pkg;

  // Transaction state of the minion.
  typedef enum logic [0:0] {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_state_e;

  // Mode 0 (CPOL=0, CPHA=0): sclk idles low, cs idles high.
  localparam logic SPI_CS_IDLE   = 1'b1;
  localparam logic SPI_SCLK_IDLE = 1'b0;
  localparam logic SPI_MOSI_IDLE = 1'b0;

  // Bit counter must hold values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_en_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_en_reg                                                   |
// | Description : Generic load-enable register with asynchronous reset value.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_en_reg #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Hold the current value unless a load is requested.
  always_comb begin
    q_d = en ? d : q_q;
  end

  // Storage with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_sync_edge                                                |
// | Description : nsync-deep synchronizer for an asynchronous input, with      |
// |               one-cycle rise and fall strobes on the synchronized level.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_sync_edge #(
  parameter int   nsync   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [nsync-1:0] sync_q;
  logic [nsync-1:0] sync_d;
  logic             prev_q;
  logic             prev_d;

  // Shift the raw input through the chain; remember last synchronized level.
  always_comb begin
    sync_d = {sync_q[nsync-2:0], din};
    prev_d = sync_q[nsync-1];
  end

  // Chain and history flops reset to the line's idle level so no edge fires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {nsync{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[nsync-1] & ~prev_q;
  assign fall = ~sync_q[nsync-1] & prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_minion_valrdy.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_minion_valrdy                                            |
// | Description : SPI mode-0 minion. Oversamples cs/sclk/mosi in clk, delivers |
// |               received packets on a val/rdy send port and takes reply      |
// |               words from a one-entry val/rdy recv buffer.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_minion_valrdy
  import spi_pkg::*;
#(
  parameter int nbits = 34,
  parameter int nsync = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  input  logic             recv_val,
  output logic             recv_rdy,
  input  logic [nbits-1:0] recv_msg,
  output logic             send_val,
  input  logic             send_rdy,
  output logic [nbits-1:0] send_msg,
  output logic             overflow,
  output logic             underflow
);

  localparam int             CNT_W   = cnt_width(nbits);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(nbits);

  // Synchronized strobes from the master's control lines.
  logic cs_rise;
  logic cs_fall;
  logic sck_rise;
  logic sck_fall;

  spi_sync_edge #(
    .nsync   (nsync),
    .RST_VAL (SPI_CS_IDLE)
  ) u_cs_sync (
    .clk   (clk),
    .reset (reset),
    .din   (cs),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_sync_edge #(
    .nsync   (nsync),
    .RST_VAL (SPI_SCLK_IDLE)
  ) u_sclk_sync (
    .clk   (clk),
    .reset (reset),
    .din   (sclk),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  // mosi needs only a level: same depth as sclk keeps them aligned.
  logic [nsync-1:0] mosi_sync_q;
  logic [nsync-1:0] mosi_sync_d;
  logic             mosi_s;

  // Shift raw mosi through its synchronizer chain.
  always_comb begin
    mosi_sync_d = {mosi_sync_q[nsync-2:0], mosi};
  end

  // mosi synchronizer flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mosi_sync_q <= {nsync{SPI_MOSI_IDLE}};
    end else begin
      mosi_sync_q <= mosi_sync_d;
    end
  end

  assign mosi_s = mosi_sync_q[nsync-1];

  // One-entry reply buffer. A load and a take never coincide because the
  // buffer only accepts while empty and is only taken while full.
  logic             recv_fire;
  logic             tx_take;
  logic             tx_full;
  logic [nbits-1:0] tx_buf;

  assign recv_rdy  = ~tx_full;
  assign recv_fire = recv_val & recv_rdy;

  spi_en_reg #(
    .WIDTH   (nbits),
    .RST_VAL ('0)
  ) u_tx_buf (
    .clk   (clk),
    .reset (reset),
    .en    (recv_fire),
    .d     (recv_msg),
    .q     (tx_buf)
  );

  spi_en_reg #(
    .WIDTH   (1),
    .RST_VAL (1'b0)
  ) u_tx_full (
    .clk   (clk),
    .reset (reset),
    .en    (recv_fire | tx_take),
    .d     (recv_fire),
    .q     (tx_full)
  );

  // Transaction state and shift registers.
  spi_state_e       state_q, state_d;
  logic [nbits-1:0] rx_q, rx_d;
  logic [nbits-1:0] tx_q, tx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             send_val_q, send_val_d;
  logic [nbits-1:0] send_msg_q, send_msg_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  // Next-state logic for the transaction FSM and the send port.
  always_comb begin
    state_d     = state_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    cnt_d       = cnt_q;
    send_val_d  = send_val_q & ~send_rdy;
    send_msg_d  = send_msg_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    tx_take     = 1'b0;

    case (state_q)
      SPI_IDLE: begin
        if (cs_fall) begin
          state_d = SPI_ACTIVE;
          rx_d    = '0;
          cnt_d   = '0;
          if (tx_full) begin
            tx_d    = tx_buf;
            tx_take = 1'b1;
          end else begin
            tx_d        = '0;
            underflow_d = 1'b1;
          end
        end
      end

      SPI_ACTIVE: begin
        if (sck_rise) begin
          rx_d = {rx_q[nbits-2:0], mosi_s};
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        if (sck_fall) begin
          tx_d = {tx_q[nbits-2:0], 1'b0};
        end
        if (cs_rise) begin
          state_d = SPI_IDLE;
          if (cnt_q != '0) begin
            // A fresh delivery overrides a same-cycle consume.
            if (!send_val_q || send_rdy) begin
              send_msg_d = rx_q;
              send_val_d = 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
          end
        end
      end

      default: state_d = SPI_IDLE;
    endcase
  end

  // Register FSM state, datapath and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SPI_IDLE;
      rx_q        <= '0;
      tx_q        <= '0;
      cnt_q       <= '0;
      send_val_q  <= 1'b0;
      send_msg_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      cnt_q       <= cnt_d;
      send_val_q  <= send_val_d;
      send_msg_q  <= send_msg_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign miso      = (state_q == SPI_ACTIVE) & tx_q[nbits-1];
  assign send_val  = send_val_q;
  assign send_msg  = send_msg_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
`default_nettype wire
